// File: rtl/fetch_stage_pkg.sv
// Shared MIPS fetch/decode constants: reset vector, bubble word, PC increment and
// primary opcode encodings used by the decode-stage classifier.
package fetch_stage_pkg;

  localparam logic [31:0] RESET_PC_DEF  = 32'h0040_0000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;
  localparam logic [31:0] PC_INC        = 32'd4;

  typedef enum logic [5:0] {
    OP_SPECIAL = 6'h00,
    OP_REGIMM  = 6'h01,
    OP_J       = 6'h02,
    OP_JAL     = 6'h03,
    OP_BEQ     = 6'h04,
    OP_BNE     = 6'h05,
    OP_BLEZ    = 6'h06,
    OP_BGTZ    = 6'h07,
    OP_ADDI    = 6'h08,
    OP_LW      = 6'h23,
    OP_SW      = 6'h2B
  } opcode_t;

  function automatic opcode_t opcode_of(input logic [31:0] instr);
    return opcode_t'(instr[31:26]);
  endfunction

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: instruction, PC+4 and valid bit with
// reset > bubble > hold > load priority.
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bubble,
  input  logic        hold,
  input  logic [31:0] fetch_instr,
  input  logic [31:0] fetch_pc_plus4,
  output logic [31:0] instr_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d
);

  // IF -> ID boundary
  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      instr_d    <= NOP_INSTR;
      pc_plus4_d <= 32'd0;
      valid_d    <= 1'b0;
    end else if (!hold) begin
      instr_d    <= fetch_instr;
      pc_plus4_d <= fetch_pc_plus4;
      valid_d    <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC ownership, redirect/stall/halt handling and
// the IF/ID register feeding decode.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_f,
  input  logic        flush_d,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_f,
  output logic [31:0] instr_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d,
  output logic        halted,
  output logic        addr_err
);

  logic [31:0] pc_next;
  logic [31:0] pc_plus4;
  logic        misaligned;
  logic        bubble;

  assign imem_addr = pc_f;
  assign pc_plus4  = pc_f + PC_INC;

  // A redirect arriving while frozen is ignored, so it cannot raise addr_err either.
  assign misaligned = redirect_valid && !halted && (redirect_pc[1:0] != 2'b00);

  // Wrong-path and post-halt words never reach decode.
  assign bubble = flush_d || redirect_valid || halt_req || halted;

  always_comb begin
    pc_next = pc_f;
    if (halted)
      pc_next = pc_f;
    else if (redirect_valid)
      pc_next = word_align(redirect_pc);
    else if (!stall_f)
      pc_next = pc_plus4;
  end

  // PC / status boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_f     <= RESET_PC;
      halted   <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      pc_f <= pc_next;
      if (halt_req || misaligned)
        halted <= 1'b1;
      if (misaligned)
        addr_err <= 1'b1;
    end
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk            (clk),
    .rst            (rst),
    .bubble         (bubble),
    .hold           (stall_f),
    .fetch_instr    (imem_rdata),
    .fetch_pc_plus4 (pc_plus4),
    .instr_d        (instr_d),
    .pc_plus4_d     (pc_plus4_d),
    .valid_d        (valid_d)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: each directed cycle pushes its expected
// post-edge state; a negedge monitor pops and compares.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall_f;
  logic        flush_d;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] pc_f;
  logic [31:0] instr_d;
  logic [31:0] pc_plus4_d;
  logic        valid_d;
  logic        halted;
  logic        addr_err;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pp4;
    logic        v;
    logic        h;
    logic        a;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  // Instruction memory returns the inverted address so instr_d and pc_plus4_d differ.
  assign imem_rdata = ~imem_addr;

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall_f        (stall_f),
    .flush_d        (flush_d),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .pc_f           (pc_f),
    .instr_d        (instr_d),
    .pc_plus4_d     (pc_plus4_d),
    .valid_d        (valid_d),
    .halted         (halted),
    .addr_err       (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (pc_f === e.pc && imem_addr === e.pc && instr_d === e.instr &&
          pc_plus4_d === e.pp4 && valid_d === e.v && halted === e.h && addr_err === e.a)
        passed++;
      else
        $display("FAIL cycle%0d: got pc=%h addr=%h instr=%h pp4=%h v=%b h=%b a=%b, want pc=%h instr=%h pp4=%h v=%b h=%b a=%b",
                 checks, pc_f, imem_addr, instr_d, pc_plus4_d, valid_d, halted, addr_err,
                 e.pc, e.instr, e.pp4, e.v, e.h, e.a);
    end
  end

  task automatic cyc(input logic r, input logic s, input logic f, input logic rv,
                     input logic [31:0] rpc, input logic hr,
                     input logic [31:0] e_pc, input logic [31:0] e_instr,
                     input logic [31:0] e_pp4, input logic e_v, input logic e_h,
                     input logic e_a);
    exp_t e;
    rst = r; stall_f = s; flush_d = f; redirect_valid = rv; redirect_pc = rpc; halt_req = hr;
    e.pc = e_pc; e.instr = e_instr; e.pp4 = e_pp4; e.v = e_v; e.h = e_h; e.a = e_a;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int wait_cycles;
    //  r  s  f  rv redirect_pc     hr  pc              instr           pp4             v  h  a
    cyc(1, 0, 0, 0, 32'h0,         0, 32'h0040_0000, 32'h0000_0000, 32'h0000_0000, 0, 0, 0);
    cyc(0, 0, 0, 0, 32'h0,         0, 32'h0040_0004, 32'hFFBF_FFFF, 32'h0040_0004, 1, 0, 0);
    cyc(0, 0, 0, 0, 32'h0,         0, 32'h0040_0008, 32'hFFBF_FFFB, 32'h0040_0008, 1, 0, 0);
    // stall two cycles at 0040_0008
    cyc(0, 1, 0, 0, 32'h0,         0, 32'h0040_0008, 32'hFFBF_FFFB, 32'h0040_0008, 1, 0, 0);
    cyc(0, 1, 0, 0, 32'h0,         0, 32'h0040_0008, 32'hFFBF_FFFB, 32'h0040_0008, 1, 0, 0);
    cyc(0, 0, 0, 0, 32'h0,         0, 32'h0040_000C, 32'hFFBF_FFF7, 32'h0040_000C, 1, 0, 0);
    cyc(0, 0, 0, 0, 32'h0,         0, 32'h0040_0010, 32'hFFBF_FFF3, 32'h0040_0010, 1, 0, 0);
    // redirect beats stall
    cyc(0, 1, 0, 1, 32'h0040_0100, 0, 32'h0040_0100, 32'h0000_0000, 32'h0000_0000, 0, 0, 0);
    cyc(0, 0, 0, 0, 32'h0,         0, 32'h0040_0104, 32'hFFBF_FEFF, 32'h0040_0104, 1, 0, 0);
    // flush beats stall, pc held
    cyc(0, 1, 1, 0, 32'h0,         0, 32'h0040_0104, 32'h0000_0000, 32'h0000_0000, 0, 0, 0);
    cyc(0, 0, 0, 0, 32'h0,         0, 32'h0040_0108, 32'hFFBF_FEFB, 32'h0040_0108, 1, 0, 0);
    // halt pulse, then frozen; redirect while halted ignored
    cyc(0, 0, 0, 0, 32'h0,         1, 32'h0040_010C, 32'h0000_0000, 32'h0000_0000, 0, 1, 0);
    cyc(0, 0, 0, 0, 32'h0,         0, 32'h0040_010C, 32'h0000_0000, 32'h0000_0000, 0, 1, 0);
    cyc(0, 0, 0, 0, 32'h0,         0, 32'h0040_010C, 32'h0000_0000, 32'h0000_0000, 0, 1, 0);
    cyc(0, 0, 0, 1, 32'h0040_0203, 0, 32'h0040_010C, 32'h0000_0000, 32'h0000_0000, 0, 1, 0);
    cyc(1, 0, 0, 0, 32'h0,         0, 32'h0040_0000, 32'h0000_0000, 32'h0000_0000, 0, 0, 0);
    cyc(0, 0, 0, 0, 32'h0,         0, 32'h0040_0004, 32'hFFBF_FFFF, 32'h0040_0004, 1, 0, 0);
    // misaligned redirect
    cyc(0, 0, 0, 1, 32'h0040_0102, 0, 32'h0040_0100, 32'h0000_0000, 32'h0000_0000, 0, 1, 1);
    cyc(0, 0, 0, 0, 32'h0,         0, 32'h0040_0100, 32'h0000_0000, 32'h0000_0000, 0, 1, 1);
    cyc(1, 0, 0, 0, 32'h0,         0, 32'h0040_0000, 32'h0000_0000, 32'h0000_0000, 0, 0, 0);
    // PC wrap at top of address space
    cyc(0, 0, 0, 1, 32'hFFFF_FFF8, 0, 32'hFFFF_FFF8, 32'h0000_0000, 32'h0000_0000, 0, 0, 0);
    cyc(0, 0, 0, 0, 32'h0,         0, 32'hFFFF_FFFC, 32'h0000_0007, 32'hFFFF_FFFC, 1, 0, 0);
    cyc(0, 0, 0, 0, 32'h0,         0, 32'h0000_0000, 32'h0000_0003, 32'h0000_0000, 1, 0, 0);
    cyc(0, 0, 0, 0, 32'h0,         0, 32'h0000_0004, 32'hFFFF_FFFF, 32'h0000_0004, 1, 0, 0);
    // halt and redirect on the same edge
    cyc(0, 0, 0, 1, 32'h0040_0300, 1, 32'h0040_0300, 32'h0000_0000, 32'h0000_0000, 0, 1, 0);
    cyc(0, 0, 0, 0, 32'h0,         0, 32'h0040_0300, 32'h0000_0000, 32'h0000_0000, 0, 1, 0);
    // reset overrides everything else
    cyc(1, 1, 1, 1, 32'h0040_0500, 1, 32'h0040_0000, 32'h0000_0000, 32'h0000_0000, 0, 0, 0);
    cyc(0, 0, 0, 0, 32'h0,         0, 32'h0040_0004, 32'hFFBF_FFFF, 32'h0040_0004, 1, 0, 0);
    cyc(0, 1, 0, 0, 32'h0,         0, 32'h0040_0004, 32'hFFBF_FFFF, 32'h0040_0004, 1, 0, 0);

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
